// File: rtl/buffer_pkg.sv
// Shared types for the word-pair buffers: default word width, unpacker
// states and the pair layout (word0 is the earlier word).
package buffer_pkg;

   localparam int BUF_N = 32;

   typedef enum logic {
      S_FIRST,
      S_SECOND
   } state_t;

   typedef struct packed {
      logic [BUF_N-1:0] word0;
      logic [BUF_N-1:0] word1;
   } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever
// the FIFO is not empty, and reads as zero when it is empty.
module pair_fifo
   import buffer_pkg::*;
#(
   parameter int W     = 2*BUF_N,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Occupancy comes from count alone, so the pointers may wrap freely.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/buffer_unpack.sv
// Groups a serial word stream into (earlier, later) pairs and queues them
// for a valid/ready consumer on out0/out1.
module buffer_unpack
   import buffer_pkg::*;
#(
   parameter int N     = BUF_N,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N-1:0]                 in,
   input  logic                         in_en,
   output logic                         in_rdy,
   output logic [N-1:0]                 out0,
   output logic [N-1:0]                 out1,
   output logic                         out_en,
   input  logic                         out_rdy,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   state_t         state;
   state_t         next_state;
   logic [N-1:0]   hold;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic [2*N-1:0] fifo_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FIRST;
      end else begin
         state <= next_state;
      end
   end

   // in_rdy only looks at full, never at out_rdy, to keep the paths apart.
   always_comb begin
      next_state = state;
      in_rdy     = 1'b0;
      push       = 1'b0;
      case (state)
         S_FIRST: begin
            in_rdy = 1'b1;
            if (in_en) begin
               next_state = S_SECOND;
            end
         end
         S_SECOND: begin
            in_rdy = !full;
            if (in_en && !full) begin
               push       = 1'b1;
               next_state = S_FIRST;
            end
         end
         default: begin
            next_state = S_FIRST;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
      end else if (state == S_FIRST && in_en) begin
         hold <= in;
      end
   end

   assign out_en        = !empty;
   assign pop           = out_en && out_rdy;
   assign {out0, out1}  = fifo_dout;

   pair_fifo #(
      .W     (2*N),
      .DEPTH (DEPTH)
   ) u_pair_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({hold, in}),
      .dout  (fifo_dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule
